// File: rtl/updown_seq_checker.sv
// Sequence checker for an up/down ping-pong counter stream (0..MAX..0).
// Locks onto the stream after two consistent samples, then flags and counts every deviation.
module updown_seq_checker #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [WIDTH-1:0] q,
  output logic             locked,
  output logic             dir_up,
  output logic             err,
  output logic [7:0]       err_count,
  output logic [7:0]       turn_count
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

  localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] exp_q;
  logic             turn;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Prediction: the two endpoints are handled explicitly so exp_q never wraps.
  always_comb begin
    exp_q = prev + ONE;
    turn  = 1'b0;
    if (dir_up) begin
      if (prev == MAX) begin
        exp_q = MAX - ONE;
        turn  = 1'b1;
      end
    end else if (prev == ZERO) begin
      exp_q = ONE;
      turn  = 1'b1;
    end else begin
      exp_q = prev - ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      prev       <= '0;
      locked     <= 1'b0;
      dir_up     <= 1'b1;
      err        <= 1'b0;
      err_count  <= 8'd0;
      turn_count <= 8'd0;
    end else begin
      err <= 1'b0;
      if (valid) begin
        prev <= q;
        unique case (state)
          IDLE: begin
            state <= ACQ;
          end
          ACQ: begin
            if ((q == prev + ONE) && (prev != MAX)) begin
              dir_up <= 1'b1;
              state  <= LOCK;
              locked <= 1'b1;
            end else if ((q == prev - ONE) && (prev != ZERO)) begin
              dir_up <= 1'b0;
              state  <= LOCK;
              locked <= 1'b1;
            end
          end
          LOCK: begin
            if (q == exp_q) begin
              if (turn) begin
                dir_up     <= ~dir_up;
                turn_count <= turn_count + 8'd1;
              end
            end else begin
              // Drop lock but keep the old direction; reacquire from this sample.
              err       <= 1'b1;
              err_count <= sat_inc8(err_count);
              locked    <= 1'b0;
              state     <= ACQ;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_updown_seq_checker.sv
// Bench for updown_seq_checker: hand-derived vector table plus corner sequences,
// expected outputs queued on drive and popped after the sampling edge.
module tb_updown_seq_checker;

  typedef struct packed {
    logic       locked;
    logic       dir_up;
    logic       err;
    logic [7:0] ec;
    logic [7:0] tc;
  } out_t;

  typedef struct {
    logic       vld;
    logic [2:0] q;
    out_t       req;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic [2:0] q = 3'd0;
  logic       valid4 = 1'b0;
  logic [3:0] q4 = 4'd0;

  logic       locked, dir_up, err;
  logic [7:0] err_count, turn_count;
  logic       locked4, dir_up4, err4;
  logic [7:0] err_count4, turn_count4;

  int   checks = 0;
  int   failures = 0;
  out_t sb[$];
  out_t sb4[$];
  vec_t tbl[$];

  updown_seq_checker #(.WIDTH(3)) dut (
    .clk(clk), .reset(reset), .valid(valid), .q(q),
    .locked(locked), .dir_up(dir_up), .err(err),
    .err_count(err_count), .turn_count(turn_count)
  );

  updown_seq_checker #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .valid(valid4), .q(q4),
    .locked(locked4), .dir_up(dir_up4), .err(err4),
    .err_count(err_count4), .turn_count(turn_count4)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input logic l, input logic d, input logic e, input int ec, input int tc);
    out_t r;
    r.locked = l;
    r.dir_up = d;
    r.err    = e;
    r.ec     = ec[7:0];
    r.tc     = tc[7:0];
    return r;
  endfunction

  function automatic void add(input logic v, input logic [2:0] qq, input out_t r);
    vec_t t;
    t.vld = v;
    t.q   = qq;
    t.req = r;
    tbl.push_back(t);
  endfunction

  function automatic out_t act3();
    out_t a;
    a = {locked, dir_up, err, err_count, turn_count};
    return a;
  endfunction

  function automatic out_t act4();
    out_t a;
    a = {locked4, dir_up4, err4, err_count4, turn_count4};
    return a;
  endfunction

  task automatic check(input string name, input out_t a, input out_t r);
    checks++;
    if (a !== r) begin
      failures++;
      $display("FAIL %s: got locked=%0b dir_up=%0b err=%0b err_count=%0d turn_count=%0d, want locked=%0b dir_up=%0b err=%0b err_count=%0d turn_count=%0d",
               name, a.locked, a.dir_up, a.err, a.ec, a.tc, r.locked, r.dir_up, r.err, r.ec, r.tc);
    end
  endtask

  task automatic drive(input string name, input logic v, input logic [2:0] qq, input out_t r);
    out_t req;
    @(negedge clk);
    valid = v;
    q     = qq;
    sb.push_back(r);
    @(posedge clk);
    #1;
    req = sb.pop_front();
    check(name, act3(), req);
  endtask

  task automatic drive4(input string name, input logic [3:0] qq, input out_t r);
    out_t req;
    @(negedge clk);
    valid4 = 1'b1;
    q4     = qq;
    sb4.push_back(r);
    @(posedge clk);
    #1;
    req = sb4.pop_front();
    check(name, act4(), req);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    valid  = 1'b0;
    valid4 = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    out_t rst_v;
    int   ec;
    rst_v = mk(1'b0, 1'b1, 1'b0, 0, 0);

    // Reset state, checked while reset is still held low.
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", act3(), rst_v);
    check("reset_state_w4", act4(), rst_v);
    reset = 1'b1;

    // Full ping-pong pass 0..7..0,1.
    add(1'b1, 3'd0, mk(1'b0, 1'b1, 1'b0, 0, 0));
    for (int v = 1; v <= 7; v++) add(1'b1, 3'(v), mk(1'b1, 1'b1, 1'b0, 0, 0));
    add(1'b1, 3'd6, mk(1'b1, 1'b0, 1'b0, 0, 1));
    for (int v = 5; v >= 0; v--) add(1'b1, 3'(v), mk(1'b1, 1'b0, 1'b0, 0, 1));
    add(1'b1, 3'd1, mk(1'b1, 1'b1, 1'b0, 0, 2));
    // Locked up-stream, a skipped value, then reacquisition.
    add(1'b1, 3'd2, mk(1'b1, 1'b1, 1'b0, 0, 2));
    add(1'b1, 3'd3, mk(1'b1, 1'b1, 1'b0, 0, 2));
    add(1'b1, 3'd4, mk(1'b1, 1'b1, 1'b0, 0, 2));
    add(1'b1, 3'd6, mk(1'b0, 1'b1, 1'b1, 1, 2));
    add(1'b1, 3'd7, mk(1'b1, 1'b1, 1'b0, 1, 2));
    add(1'b1, 3'd6, mk(1'b1, 1'b0, 1'b0, 1, 3));
    // Gap in valid: held outputs, garbage q ignored.
    add(1'b1, 3'd5, mk(1'b1, 1'b0, 1'b0, 1, 3));
    add(1'b1, 3'd4, mk(1'b1, 1'b0, 1'b0, 1, 3));
    for (int g = 0; g < 5; g++) add(1'b0, 3'(g + 1), mk(1'b1, 1'b0, 1'b0, 1, 3));
    add(1'b1, 3'd3, mk(1'b1, 1'b0, 1'b0, 1, 3));
    // Repeated value: mismatch while locked, no lock while acquiring.
    add(1'b1, 3'd3, mk(1'b0, 1'b0, 1'b1, 2, 3));
    add(1'b1, 3'd3, mk(1'b0, 1'b0, 1'b0, 2, 3));
    add(1'b1, 3'd3, mk(1'b0, 1'b0, 1'b0, 2, 3));
    add(1'b1, 3'd2, mk(1'b1, 1'b0, 1'b0, 2, 3));

    for (int i = 0; i < tbl.size(); i++)
      drive($sformatf("vec%0d", i), tbl[i].vld, tbl[i].q, tbl[i].req);

    // Asynchronous reset mid-stream with turn_count = 1.
    reset_pulse();
    for (int v = 0; v <= 7; v++)
      drive($sformatf("pre_rst%0d", v), 1'b1, 3'(v), mk(v > 0, 1'b1, 1'b0, 0, 0));
    drive("pre_rst_turn", 1'b1, 3'd6, mk(1'b1, 1'b0, 1'b0, 0, 1));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_reset_immediate", act3(), rst_v);
    valid = 1'b1;
    q     = 3'd5;
    @(posedge clk);
    #1;
    check("reset_held", act3(), rst_v);
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b0;
    drive("post_rst_s1", 1'b1, 3'd5, mk(1'b0, 1'b1, 1'b0, 0, 0));
    drive("post_rst_s2", 1'b1, 3'd4, mk(1'b1, 1'b0, 1'b0, 0, 0));

    // 300 lock/mismatch rounds: err_count saturates at 255.
    reset_pulse();
    for (int k = 0; k < 300; k++) begin
      ec = (k > 255) ? 255 : k;
      drive($sformatf("sat%0d_a", k), 1'b1, 3'd2, mk(1'b0, 1'b1, 1'b0, ec, 0));
      drive($sformatf("sat%0d_b", k), 1'b1, 3'd3, mk(1'b1, 1'b1, 1'b0, ec, 0));
      ec = (k + 1 > 255) ? 255 : k + 1;
      drive($sformatf("sat%0d_c", k), 1'b1, 3'd0, mk(1'b0, 1'b1, 1'b1, ec, 0));
    end
    drive("sat_hold_a", 1'b1, 3'd2, mk(1'b0, 1'b1, 1'b0, 255, 0));
    drive("sat_hold_b", 1'b1, 3'd3, mk(1'b1, 1'b1, 1'b0, 255, 0));

    // WIDTH = 4 instance: one full pass 0..15..0.
    reset_pulse();
    for (int i = 0; i <= 30; i++)
      drive4($sformatf("w4_%0d", i), 4'((i <= 15) ? i : 30 - i),
             mk(i >= 1, i < 16, 1'b0, 0, (i >= 16) ? 1 : 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
